// File: rtl/cmp_threshold_monitor.sv
// rtl/cmp_threshold_monitor.sv - debounced threshold crossing monitor with event buffer and counters
module cmp_threshold_monitor #(
    parameter int unsigned DEBOUNCE = 3,
    parameter int unsigned CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic             lower,
    input  logic             equal,
    input  logic             greater,
    output logic             above,
    output logic             evt_valid,
    output logic             evt_rise,
    input  logic             evt_ready,
    output logic             evt_ovf,
    output logic             flag_err,
    output logic [CNT_W-1:0] lo_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] gr_cnt
);

    typedef enum logic {
        ST_BELOW = 1'b0,
        ST_ABOVE = 1'b1
    } state_e;

    localparam logic [3:0]       DEB     = 4'(DEBOUNCE);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [3:0]       run_q, run_d;
    logic             evt_valid_q, evt_valid_d;
    logic             evt_rise_q, evt_rise_d;
    logic             evt_ovf_q, evt_ovf_d;
    logic             flag_err_q, flag_err_d;
    logic [CNT_W-1:0] lo_cnt_q, lo_cnt_d;
    logic [CNT_W-1:0] eq_cnt_q, eq_cnt_d;
    logic [CNT_W-1:0] gr_cnt_q, gr_cnt_d;

    logic legal;
    logic qualify;
    logic new_evt;
    logic new_rise;

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        evt_valid_d = evt_valid_q;
        evt_rise_d  = evt_rise_q;
        evt_ovf_d   = evt_ovf_q;
        flag_err_d  = flag_err_q;
        lo_cnt_d    = lo_cnt_q;
        eq_cnt_d    = eq_cnt_q;
        gr_cnt_d    = gr_cnt_q;
        new_evt     = 1'b0;
        new_rise    = 1'b0;
        legal       = $onehot({lower, equal, greater});
        // Equal never qualifies: it is the hysteresis dead band in both states.
        qualify     = (state_q == ST_BELOW) ? greater : lower;

        if (in_valid) begin
            if (!legal) begin
                flag_err_d = 1'b1;
            end else begin
                if (lower   && lo_cnt_q != CNT_MAX) lo_cnt_d = lo_cnt_q + CNT_ONE;
                if (equal   && eq_cnt_q != CNT_MAX) eq_cnt_d = eq_cnt_q + CNT_ONE;
                if (greater && gr_cnt_q != CNT_MAX) gr_cnt_d = gr_cnt_q + CNT_ONE;

                if (!qualify) begin
                    run_d = '0;
                end else if (run_q + 4'd1 == DEB) begin
                    run_d    = '0;
                    new_evt  = 1'b1;
                    new_rise = (state_q == ST_BELOW);
                    state_d  = (state_q == ST_BELOW) ? ST_ABOVE : ST_BELOW;
                end else begin
                    run_d = run_q + 4'd1;
                end
            end
        end

        // A full buffer accepts a new event only when its occupant pops this same cycle.
        if (new_evt) begin
            if (!evt_valid_q || evt_ready) begin
                evt_valid_d = 1'b1;
                evt_rise_d  = new_rise;
            end else begin
                evt_ovf_d = 1'b1;
            end
        end else if (evt_valid_q && evt_ready) begin
            evt_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BELOW;
            run_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_rise_q  <= 1'b0;
            evt_ovf_q   <= 1'b0;
            flag_err_q  <= 1'b0;
            lo_cnt_q    <= '0;
            eq_cnt_q    <= '0;
            gr_cnt_q    <= '0;
        end else if (clear) begin
            state_q     <= ST_BELOW;
            run_q       <= '0;
            evt_valid_q <= 1'b0;
            evt_rise_q  <= 1'b0;
            evt_ovf_q   <= 1'b0;
            flag_err_q  <= 1'b0;
            lo_cnt_q    <= '0;
            eq_cnt_q    <= '0;
            gr_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            evt_valid_q <= evt_valid_d;
            evt_rise_q  <= evt_rise_d;
            evt_ovf_q   <= evt_ovf_d;
            flag_err_q  <= flag_err_d;
            lo_cnt_q    <= lo_cnt_d;
            eq_cnt_q    <= eq_cnt_d;
            gr_cnt_q    <= gr_cnt_d;
        end
    end

    assign above     = (state_q == ST_ABOVE);
    assign evt_valid = evt_valid_q;
    assign evt_rise  = evt_rise_q;
    assign evt_ovf   = evt_ovf_q;
    assign flag_err  = flag_err_q;
    assign lo_cnt    = lo_cnt_q;
    assign eq_cnt    = eq_cnt_q;
    assign gr_cnt    = gr_cnt_q;

endmodule
